// File: rtl/fp_pkg.sv
// fp_pkg: flag indices, flag type and NaN helpers shared by the divider result path
package fp_pkg;
  localparam int FLG_NV = 3;
  localparam int FLG_DZ = 2;
  localparam int FLG_OF = 1;
  localparam int FLG_UF = 0;
  typedef logic [3:0] fp_flags_t;
  function automatic logic [63:0] canon_nan(input int exp_w, input int frac_w);
    return (((64'd1 << exp_w) - 64'd1) << frac_w) | (64'd1 << (frac_w - 1));
  endfunction
  function automatic logic is_nan(input logic [63:0] w, input int exp_w, input int frac_w);
    logic [63:0] e_mask;
    logic [63:0] f_mask;
    e_mask = (64'd1 << exp_w) - 64'd1;
    f_mask = (64'd1 << frac_w) - 64'd1;
    return (((w >> frac_w) & e_mask) == e_mask) && ((w & f_mask) != 64'd0);
  endfunction
endpackage

// File: rtl/fp_result_store.sv
// fp_result_store: DEPTH-entry register array, one write port and one asynchronous read port
module fp_result_store #(
  parameter int DW    = 36,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  assign rdata = mem[raddr];
endmodule

// File: rtl/fp_result_fifo.sv
// fp_result_fifo: buffers divider results with sticky flags; FP_CANON_NAN_EN canonicalises NaNs on push
module fp_result_fifo
  import fp_pkg::*;
#(
  parameter int EXP   = 8,
  parameter int FRAC  = 23,
  parameter int WIDTH = EXP + FRAC + 1,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_r,
  input  logic [3:0]               in_flags,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_r,
  output logic [3:0]               out_flags,
  output logic [3:0]               sticky_flags,
  input  logic                     sticky_clr,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  fp_flags_t sticky_q, sticky_d, st_flags, rd_flags;
  logic [WIDTH-1:0] st_r, rd_r;
  logic full, empty, push, pop;
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty     = wr_ptr_q == rd_ptr_q;
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
`ifdef FP_CANON_NAN_EN
  logic nan;
  assign nan      = is_nan(64'(in_r), EXP, FRAC);
  assign st_r     = nan ? WIDTH'(canon_nan(EXP, FRAC)) : in_r;
  assign st_flags = in_flags | (fp_flags_t'(nan) << FLG_NV);
`else
  assign st_r     = in_r;
  assign st_flags = in_flags;
`endif
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    sticky_d = (sticky_clr ? '0 : sticky_q) | (push ? st_flags : '0);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      sticky_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      sticky_q <= sticky_d;
    end
  end
  fp_result_store #(.DW(WIDTH + 4), .DEPTH(DEPTH), .AW(AW)) u_store (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr_q[AW-1:0]),
    .wdata({st_flags, st_r}),
    .raddr(rd_ptr_q[AW-1:0]),
    .rdata({rd_flags, rd_r})
  );
  // storage is not reset, so the head is masked while empty
  assign out_r        = empty ? '0 : rd_r;
  assign out_flags    = empty ? '0 : rd_flags;
  assign sticky_flags = sticky_q;
  assign count        = wr_ptr_q - rd_ptr_q;
endmodule

// File: tb/tb_fp_result_fifo.sv
// tb_fp_result_fifo: table-driven vectors with a queue scoreboard for fp_result_fifo
module tb_fp_result_fifo;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, out_ready = 0, sticky_clr = 0;
  logic [31:0] in_r = '0;
  logic [3:0] in_flags = '0;
  logic in_ready, out_valid;
  logic [31:0] out_r;
  logic [3:0] out_flags, sticky_flags;
  logic [2:0] count;
  int total = 0, bad = 0;
  logic [35:0] q[$];
  int mcount = 0;
  logic [3:0] msticky = '0;
  typedef struct {
    logic iv;
    logic [31:0] r;
    logic [3:0] f;
    logic ordy;
    logic clr;
    int cnt;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  fp_result_fifo dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_r(in_r), .in_flags(in_flags), .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_flags(out_flags), .sticky_flags(sticky_flags),
    .sticky_clr(sticky_clr), .count(count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [35:0] xform(input logic [31:0] r, input logic [3:0] f);
    logic [31:0] rr = r;
    logic [3:0] ff = f;
`ifdef FP_CANON_NAN_EN
    if (r[30:23] == 8'hFF && r[22:0] != 23'd0) begin
      rr = 32'h7FC00000;
      ff = f | 4'b1000;
    end
`endif
    return {ff, rr};
  endfunction

  task automatic check_state(input string tag);
    logic [35:0] head;
    head = (mcount > 0) ? q[0] : 36'd0;
    chk({tag, "_in_ready"}, 64'(in_ready), 64'(mcount != 4));
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(mcount != 0));
    chk({tag, "_count"}, 64'(count), 64'(mcount));
    chk({tag, "_out_r"}, 64'(out_r), 64'(head[31:0]));
    chk({tag, "_out_flags"}, 64'(out_flags), 64'(head[35:32]));
    chk({tag, "_sticky"}, 64'(sticky_flags), 64'(msticky));
  endtask

  task automatic step(input vec_t v);
    logic p, o;
    logic [35:0] e;
    @(negedge clk);
    in_valid = v.iv; in_r = v.r; in_flags = v.f; out_ready = v.ordy; sticky_clr = v.clr;
    #1 check_state("pre");
    p = v.iv && (mcount < 4);
    o = v.ordy && (mcount > 0);
    e = xform(v.r, v.f);
    @(posedge clk);
    if (o) void'(q.pop_front());
    if (p) q.push_back(e);
    mcount = mcount + int'(p) - int'(o);
    msticky = (v.clr ? 4'b0 : msticky) | (p ? e[35:32] : 4'b0);
    #1 chk("tbl_count", 64'(count), 64'(v.cnt));
  endtask

  function automatic vec_t mk(input logic iv, input logic [31:0] r, input logic [3:0] f,
                              input logic ordy, input logic clr, input int cnt);
    vec_t v;
    v.iv = iv; v.r = r; v.f = f; v.ordy = ordy; v.clr = clr; v.cnt = cnt;
    return v;
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1 check_state("reset");
    @(negedge clk) rst_n = 1;
    tbl.push_back(mk(1, 32'h3FC00000, 4'h0, 0, 0, 1));
    tbl.push_back(mk(0, 32'h0, 4'h0, 1, 0, 0));
    tbl.push_back(mk(1, 32'h11111111, 4'h1, 0, 0, 1));
    tbl.push_back(mk(1, 32'h22222222, 4'h2, 0, 0, 2));
    tbl.push_back(mk(1, 32'h33333333, 4'h0, 0, 0, 3));
    tbl.push_back(mk(1, 32'h44444444, 4'h0, 0, 0, 4));
    tbl.push_back(mk(1, 32'hDEADBEEF, 4'hF, 0, 0, 4));
    tbl.push_back(mk(1, 32'hDEADBEEF, 4'hF, 1, 0, 3));
    tbl.push_back(mk(0, 32'h0, 4'h0, 1, 1, 2));
    tbl.push_back(mk(0, 32'h0, 4'h0, 1, 0, 1));
    tbl.push_back(mk(0, 32'h0, 4'h0, 1, 0, 0));
    tbl.push_back(mk(0, 32'h0, 4'h0, 1, 0, 0));
    tbl.push_back(mk(1, 32'h40000000, 4'h0, 0, 0, 1));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1, 32'h40000001 + 32'(i), 4'h0, 1, 0, 1));
    tbl.push_back(mk(1, 32'h3F800000, 4'b0100, 1, 0, 1));
    tbl.push_back(mk(1, 32'h3F800001, 4'b0001, 1, 0, 1));
    tbl.push_back(mk(1, 32'h3F800002, 4'b1000, 1, 1, 1));
    tbl.push_back(mk(0, 32'h0, 4'h0, 1, 0, 0));
    tbl.push_back(mk(0, 32'h0, 4'h0, 0, 1, 0));
    tbl.push_back(mk(1, 32'hFF800001, 4'b0010, 0, 0, 1));
    tbl.push_back(mk(0, 32'h0, 4'h0, 0, 0, 1));
    tbl.push_back(mk(0, 32'h0, 4'h0, 1, 0, 0));
    foreach (tbl[i]) step(tbl[i]);
    step(mk(1, 32'hAAAA0001, 4'h1, 0, 0, 1));
    step(mk(1, 32'hAAAA0002, 4'h2, 0, 0, 2));
    step(mk(1, 32'hAAAA0003, 4'h4, 0, 0, 3));
    @(negedge clk);
    in_valid = 1; in_r = 32'hBBBB0000;
    #2 rst_n = 0;
    #1 chk("async_rst_count", 64'(count), 64'd0);
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    chk("async_rst_in_ready", 64'(in_ready), 64'd1);
    chk("async_rst_sticky", 64'(sticky_flags), 64'd0);
    q.delete(); mcount = 0; msticky = '0;
    @(negedge clk);
    in_valid = 0; rst_n = 1;
    step(mk(1, 32'hC0000000, 4'h8, 0, 0, 1));
    step(mk(0, 32'h0, 4'h0, 1, 0, 0));
    step(mk(0, 32'h0, 4'h0, 0, 0, 0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
